// File: rtl/pit_timer.sv
// Programmable interval timer: a prescaler feeding a divider down-counter.
// Produces a registered one-cycle tick per expired period and a sticky irq.
module pit_timer #(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             cen,
  input  logic             pre_wr,
  input  logic [WIDTH-1:0] pre_din,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_din,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] pre_cnt,
  output logic [WIDTH-1:0] div_cnt,
  output logic             tick,
  output logic             irq
);

  logic [WIDTH-1:0] pre_reg;
  logic [WIDTH-1:0] div_reg;
  logic             running;
  logic             step;
  logic             pre_tc;
  logic             term;

  // A zero divider parks the timer; any write edge suppresses the count step.
  always_comb begin
    running = (div_reg != '0);
    step    = cen && running && !pre_wr && !div_wr;
    pre_tc  = step && (pre_cnt == '0);
    term    = pre_tc && (div_cnt == '0);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pre_reg <= '0;
      div_reg <= '0;
      pre_cnt <= '0;
      div_cnt <= '0;
      tick    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (pre_wr) pre_reg <= pre_din;
      if (div_wr) div_reg <= div_din;

      if (pre_wr)
        pre_cnt <= pre_din;
      else if (div_wr)
        pre_cnt <= pre_reg;
      else if (step)
        pre_cnt <= pre_tc ? pre_reg : pre_cnt - WIDTH'(1);

      // Counters reload at zero instead of wrapping.
      if (div_wr)
        div_cnt <= div_din;
      else if (pre_tc)
        div_cnt <= (div_cnt == '0) ? div_reg : div_cnt - WIDTH'(1);

      tick <= term;

      if (term)
        irq <= 1'b1;
      else if (irq_ack)
        irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pit_timer.sv
// Scoreboard bench for pit_timer: stimulus queues hand-computed expected
// states per cycle, a negedge monitor pops and compares them.
module tb_pit_timer;

  localparam int WIDTH = 16;

  logic             sys_clk = 1'b0;
  logic             reset   = 1'b1;
  logic             cen     = 1'b0;
  logic             pre_wr  = 1'b0;
  logic [WIDTH-1:0] pre_din = '0;
  logic             div_wr  = 1'b0;
  logic [WIDTH-1:0] div_din = '0;
  logic             irq_ack = 1'b0;
  logic [WIDTH-1:0] pre_cnt;
  logic [WIDTH-1:0] div_cnt;
  logic             tick;
  logic             irq;

  always #5 sys_clk = ~sys_clk;

  pit_timer #(.WIDTH(WIDTH)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .cen     (cen),
    .pre_wr  (pre_wr),
    .pre_din (pre_din),
    .div_wr  (div_wr),
    .div_din (div_din),
    .irq_ack (irq_ack),
    .pre_cnt (pre_cnt),
    .div_cnt (div_cnt),
    .tick    (tick),
    .irq     (irq)
  );

  typedef struct {
    int               cyc;
    string            name;
    logic [WIDTH-1:0] pre;
    logic [WIDTH-1:0] div;
    logic             tick;
    logic             irq;
  } exp_t;

  exp_t exp_q[$];
  int   tick_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Hand-computed sequences: pre_reg=1/div_reg=2 (period 6),
  // pre_reg=3/div_reg=1 (period 8), and restart pre_reg=3/div_reg=2.
  logic [WIDTH-1:0] p6_pre [6] = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1};
  logic [WIDTH-1:0] p6_div [6] = '{16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd2};
  logic             p6_tick[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [WIDTH-1:0] p8_pre [8] = '{16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0, 16'd3};
  logic [WIDTH-1:0] p8_div [8] = '{16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
  logic             p8_tick[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [WIDTH-1:0] rs_pre [5] = '{16'd2, 16'd1, 16'd0, 16'd3, 16'd2};
  logic [WIDTH-1:0] rs_div [5] = '{16'd2, 16'd2, 16'd2, 16'd1, 16'd1};

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Queue the state expected right after the next rising edge.
  task automatic expect_state(input string name, input logic [WIDTH-1:0] p,
                              input logic [WIDTH-1:0] d, input logic t, input logic i);
    exp_t e;
    e.cyc  = cyc + 1;
    e.name = name;
    e.pre  = p;
    e.div  = d;
    e.tick = t;
    e.irq  = i;
    exp_q.push_back(e);
    if (t) tick_q.push_back(cyc + 1);
  endtask

  task automatic apply_stimulus(input logic rst, input logic en, input logic pw,
                                input logic [WIDTH-1:0] pd, input logic dw,
                                input logic [WIDTH-1:0] dd, input logic ack);
    reset   = rst;
    cen     = en;
    pre_wr  = pw;
    pre_din = pd;
    div_wr  = dw;
    div_din = dd;
    irq_ack = ack;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    if (pre_cnt !== e.pre || div_cnt !== e.div || tick !== e.tick || irq !== e.irq) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got pre=%0d div=%0d tick=%b irq=%b want pre=%0d div=%0d tick=%b irq=%b",
               e.name, cyc, pre_cnt, div_cnt, tick, irq, e.pre, e.div, e.tick, e.irq);
    end
  endtask

  // Monitor: compare queued expectations and police every tick pulse.
  always @(negedge sys_clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL missed_check %s got cyc=%0d want cyc=%0d", exp_q[0].name, cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc)
      check_output(exp_q.pop_front());
    while (tick_q.size() > 0 && tick_q[0] < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL missed_tick got tick=0 want tick=1 at cyc=%0d", tick_q[0]);
      void'(tick_q.pop_front());
    end
    if (tick === 1'b1) begin
      checks++;
      if (tick_q.size() > 0 && tick_q[0] == cyc)
        void'(tick_q.pop_front());
      else begin
        errors++;
        $display("[TB] FAIL unexpected_tick got tick=1 want tick=0 at cyc=%0d", cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic irq_e;
    logic tick_e;
    logic ack;
    logic en;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] d;

    // Reset then idle: divider is zero so nothing moves.
    expect_state("reset", 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    expect_state("reset", 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      expect_state("idle", 0, 0, 0, 0);
      apply_stimulus(0, 1, 0, 0, 0, 0, 0);
    end

    // Basic period of 6.
    expect_state("basic_pre_wr", 1, 0, 0, 0);
    apply_stimulus(0, 1, 1, 1, 0, 0, 0);
    expect_state("basic_div_wr", 1, 2, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1, 2, 0);
    irq_e = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (p6_tick[k % 6]) irq_e = 1'b1;
      expect_state("basic", p6_pre[k % 6], p6_div[k % 6], p6_tick[k % 6], irq_e);
      apply_stimulus(0, 1, 0, 0, 0, 0, 0);
    end
    expect_state("ack_clear", 0, 2, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 0, 1);

    // cen gating: counters freeze on cen=0 edges, ticks 12 cycles apart.
    expect_state("gate_pre_wr", 1, 2, 0, 0);
    apply_stimulus(0, 1, 1, 1, 0, 0, 0);
    expect_state("gate_div_wr", 1, 2, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1, 2, 0);
    irq_e = 1'b0;
    p = 1;
    d = 2;
    for (int k = 0; k < 24; k++) begin
      en = (k % 2 == 0);
      tick_e = 1'b0;
      if (en) begin
        p = p6_pre[(k / 2) % 6];
        d = p6_div[(k / 2) % 6];
        tick_e = p6_tick[(k / 2) % 6];
        if (tick_e) irq_e = 1'b1;
      end
      expect_state("gate", p, d, tick_e, irq_e);
      apply_stimulus(0, en, 0, 0, 0, 0, 0);
    end

    // Simultaneous writes with ack (no terminal event, irq clears); period 8.
    expect_state("simul_write", 3, 1, 0, 0);
    apply_stimulus(0, 1, 1, 3, 1, 1, 1);
    irq_e = 1'b0;
    for (int k = 0; k < 17; k++) begin
      ack = (k == 8) || (k == 15) || (k == 16);
      tick_e = p8_tick[k % 8];
      if (tick_e) irq_e = 1'b1;
      else if (ack) irq_e = 1'b0;
      expect_state((k == 15) ? "irq_collision" : "period8", p8_pre[k % 8], p8_div[k % 8], tick_e, irq_e);
      apply_stimulus(0, 1, 0, 0, 0, 0, ack);
    end

    // Stop mid-period by writing a zero divider.
    expect_state("stop_write", 3, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      expect_state("stopped", 3, 0, 0, 0);
      apply_stimulus(0, 1, 0, 0, 0, 0, 0);
    end

    // Restart, then reset mid-count while writes are also requested.
    expect_state("restart_write", 3, 2, 0, 0);
    apply_stimulus(0, 1, 0, 0, 1, 2, 0);
    for (int k = 0; k < 5; k++) begin
      expect_state("restart", rs_pre[k], rs_div[k], 0, 0);
      apply_stimulus(0, 1, 0, 0, 0, 0, 0);
    end
    expect_state("mid_reset", 0, 0, 0, 0);
    apply_stimulus(1, 1, 1, 5, 1, 7, 0);
    for (int k = 0; k < 3; k++) begin
      expect_state("post_reset", 0, 0, 0, 0);
      apply_stimulus(0, 1, 0, 0, 0, 0, 0);
    end

    @(negedge sys_clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || tick_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got pending=%0d/%0d want 0/0", exp_q.size(), tick_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
